// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
//   Shared types and constants for the instruction sequencer slice.
//   Contents:
//     seq_state_e  - sequencer FSM states (IDLE, ARM, RUN, MEMWAIT, DONE)
//     pc_t         - program counter type at the default 10-bit PC width
//     MEM_LAT_MAX  - largest supported data-memory stretch (cycles)
//     is_active()  - true for the states in which a program is executing
// -----------------------------------------------------------------------------
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        RUN     = 3'd2,
        MEMWAIT = 3'd3,
        DONE    = 3'd4
    } seq_state_e;

    localparam int SEQ_PC_W    = 10;
    localparam int MEM_LAT_MAX = 7;

    typedef logic [SEQ_PC_W-1:0] pc_t;

    // RUN and MEMWAIT are the cycles that the watchdog and cycle counter see.
    function automatic logic is_active(input seq_state_e s);
        return (s == RUN) || (s == MEMWAIT);
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// -----------------------------------------------------------------------------
// seq_watchdog
//   Free-running saturating up-counter with synchronous clear and enable, plus
//   a compare flag that fires when the count equals CMP_VAL-1. CMP_VAL=0
//   disables the compare. Also serves as the optional program cycle counter.
//   Parameters:
//     W        counter width
//     CMP_VAL  compare value (hit when cnt == CMP_VAL-1), 0 = never hit
//   Ports:
//     clk    in   1  clock, rising edge
//     rst_n  in   1  asynchronous reset, active-low
//     clr    in   1  synchronous clear (wins over en)
//     en     in   1  count enable
//     cnt    out  W  current count, saturates at all-ones
//     hit    out  1  cnt == CMP_VAL-1 (combinational)
// -----------------------------------------------------------------------------
module seq_watchdog #(
    parameter int W       = 32,
    parameter int CMP_VAL = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         hit
);

    localparam logic         CMP_EN = (CMP_VAL != 0);
    localparam logic [W-1:0] CMP_M1 = W'(CMP_VAL - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign hit = CMP_EN && (cnt == CMP_M1);

endmodule

// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//   Program sequencer for the 9-bit-instruction core. Owns the PC, runs the
//   Start/Ack launch handshake (launch on the falling edge of Start), issues
//   one instruction per cycle, stretches data-memory ops by MEM_LAT cycles and
//   gates the register-file / data-memory write enables. A watchdog forces the
//   program to stop after TIMEOUT active cycles (TIMEOUT=0 disables it).
//
//   Optional build macro: SEQ_CYCLE_COUNT_EN
//     When defined, adds output CycleCount[31:0]: cleared in ARM, counts
//     RUN/MEMWAIT cycles, frozen in DONE, saturates at all-ones.
//
//   Parameters:
//     PC_W     PC / instruction-ROM address width
//     MEM_LAT  extra wait cycles for a data-memory op (0..7)
//     TIMEOUT  active cycles before forced stop, 0 = no watchdog
//   Ports:
//     Clk           in   1     clock, rising edge
//     Reset_n       in   1     asynchronous reset, active-low
//     Start         in   1     launch request from host
//     IsMem         in   1     current instruction accesses data memory
//     IsLoad        in   1     memory op writes the register file
//     RegWrReq      in   1     non-memory instruction writes the register file
//     MemWrReq      in   1     store instruction
//     BranchTaken   in   1     redirect PC this instruction
//     BranchTarget  in   PC_W  absolute branch target
//     IsHalt        in   1     halt instruction
//     PC            out  PC_W  instruction-ROM address
//     InstrValid    out  1     instruction executes this cycle
//     RegWrEn       out  1     gated register-file write enable
//     MemEn         out  1     data-memory access strobe
//     MemWrEn       out  1     gated data-memory write enable
//     Ack           out  1     program finished (registered)
//     TimedOut      out  1     finish caused by the watchdog (registered)
//     CycleCount    out  32    active cycle count (SEQ_CYCLE_COUNT_EN only)
// -----------------------------------------------------------------------------
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W    = 10,
    parameter int MEM_LAT = 1,
    parameter int TIMEOUT = 4096
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            Start,
    input  logic            IsMem,
    input  logic            IsLoad,
    input  logic            RegWrReq,
    input  logic            MemWrReq,
    input  logic            BranchTaken,
    input  logic [PC_W-1:0] BranchTarget,
    input  logic            IsHalt,
    output logic [PC_W-1:0] PC,
    output logic            InstrValid,
    output logic            RegWrEn,
    output logic            MemEn,
    output logic            MemWrEn,
    output logic            Ack,
    output logic            TimedOut
`ifdef SEQ_CYCLE_COUNT_EN
    ,
    output logic [31:0]     CycleCount
`endif
);

    // Out-of-range latencies are clamped to what the 3-bit wait counter holds.
    localparam int          LAT      = (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX :
                                       (MEM_LAT < 0) ? 0 : MEM_LAT;
    localparam logic [2:0]  LAT_LAST = (LAT > 0) ? 3'(LAT - 1) : 3'd0;

    seq_state_e      state;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_adv;
    logic [2:0]      mw_cnt;
    logic            ack_q;
    logic            to_q;

    logic            ivalid;
    logic            reg_wr;
    logic            mem_en;
    logic            mem_wr;
    logic            halt_go;
    logic            wd_stop;
    logic            advance;
    logic            enter_wait;
    logic            mem_last;

    logic            active;
    logic            wd_hit;
    logic [31:0]     wd_cnt;

    assign active = is_active(state);

    // One counter serves both the watchdog compare and CycleCount: both are
    // cleared in ARM and count exactly the RUN/MEMWAIT cycles.
    seq_watchdog #(
        .W       (32),
        .CMP_VAL (TIMEOUT)
    ) u_watchdog (
        .clk   (Clk),
        .rst_n (Reset_n),
        .clr   (state == ARM),
        .en    (active),
        .cnt   (wd_cnt),
        .hit   (wd_hit)
    );

`ifdef SEQ_CYCLE_COUNT_EN
    assign CycleCount = wd_cnt;
`else
    logic unused_wd_cnt;
    assign unused_wd_cnt = ^wd_cnt;
`endif

    // PC+1 wraps naturally at 2**PC_W-1.
    assign pc_adv   = BranchTaken ? BranchTarget : (pc_q + 1'b1);
    assign mem_last = (mw_cnt == LAT_LAST);

    // Decode of the current cycle: enables and the FSM's next-step decisions.
    always_comb begin
        ivalid     = 1'b0;
        reg_wr     = 1'b0;
        mem_en     = 1'b0;
        mem_wr     = 1'b0;
        halt_go    = 1'b0;
        wd_stop    = 1'b0;
        advance    = 1'b0;
        enter_wait = 1'b0;
        unique case (state)
            RUN: begin
                ivalid = 1'b1;
                if (IsHalt) begin
                    // Halt overrides every other decoder flag, including the watchdog.
                    halt_go = 1'b1;
                end else begin
                    if (IsMem) begin
                        mem_en = 1'b1;
                        mem_wr = MemWrReq;
                        if (LAT == 0) begin
                            reg_wr  = IsLoad;
                            advance = 1'b1;
                        end else begin
                            // Any branch on this instruction is taken when the op completes.
                            enter_wait = 1'b1;
                        end
                    end else begin
                        reg_wr  = RegWrReq;
                        advance = 1'b1;
                    end
                    if (wd_hit) begin
                        reg_wr     = 1'b0;
                        mem_wr     = 1'b0;
                        advance    = 1'b0;
                        enter_wait = 1'b0;
                        wd_stop    = 1'b1;
                    end
                end
            end
            MEMWAIT: begin
                mem_en = 1'b1;
                if (mem_last) begin
                    reg_wr  = IsLoad;
                    advance = 1'b1;
                end
                if (wd_hit) begin
                    reg_wr  = 1'b0;
                    advance = 1'b0;
                    wd_stop = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign PC         = pc_q;
    assign InstrValid = ivalid;
    assign RegWrEn    = reg_wr;
    assign MemEn      = mem_en;
    assign MemWrEn    = mem_wr;
    assign Ack        = ack_q;
    assign TimedOut   = to_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state  <= IDLE;
            pc_q   <= '0;
            mw_cnt <= '0;
            ack_q  <= 1'b0;
            to_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    pc_q <= '0;
                    if (Start) state <= ARM;
                end
                ARM: begin
                    pc_q  <= '0;
                    ack_q <= 1'b0;
                    to_q  <= 1'b0;
                    // Launch happens once the host drops Start.
                    if (!Start) state <= RUN;
                end
                RUN, MEMWAIT: begin
                    // Start is deliberately ignored here; only Reset_n aborts.
                    if (halt_go) begin
                        state <= DONE;
                        ack_q <= 1'b1;
                    end else if (wd_stop) begin
                        state <= DONE;
                        ack_q <= 1'b1;
                        to_q  <= 1'b1;
                    end else begin
                        if (advance) pc_q <= pc_adv;
                        if (enter_wait) begin
                            state  <= MEMWAIT;
                            mw_cnt <= '0;
                        end else if (state == MEMWAIT) begin
                            if (mem_last) state <= RUN;
                            else          mw_cnt <= mw_cnt + 3'd1;
                        end
                    end
                end
                DONE: begin
                    if (Start) begin
                        state <= ARM;
                        ack_q <= 1'b0;
                        to_q  <= 1'b0;
                        pc_q  <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_sequencer
//   Self-checking bench for instr_sequencer (MEM_LAT=2, TIMEOUT=16). The bench
//   plays the instruction ROM + decoder: decoder flags come from a ROM image
//   indexed by PC. For each program, an instruction-level model walks the ROM
//   and produces the expected per-cycle trace, which is compared against the
//   DUT outputs cycle by cycle. Honours SEQ_CYCLE_COUNT_EN.
// -----------------------------------------------------------------------------
module tb_instr_sequencer;

    localparam int PC_W    = 10;
    localparam int MEM_LAT = 2;
    localparam int TIMEOUT = 16;
    localparam int DEPTH   = 1 << PC_W;

    typedef struct packed {
        logic            is_mem;
        logic            is_load;
        logic            reg_wr;
        logic            mem_wr;
        logic            br;
        logic            halt;
        logic [PC_W-1:0] tgt;
    } op_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            v;
        logic            rw;
        logic            me;
        logic            mw;
    } cyc_t;

    logic            Clk;
    logic            Reset_n;
    logic            Start;
    logic            IsMem;
    logic            IsLoad;
    logic            RegWrReq;
    logic            MemWrReq;
    logic            BranchTaken;
    logic [PC_W-1:0] BranchTarget;
    logic            IsHalt;
    logic [PC_W-1:0] PC;
    logic            InstrValid;
    logic            RegWrEn;
    logic            MemEn;
    logic            MemWrEn;
    logic            Ack;
    logic            TimedOut;
`ifdef SEQ_CYCLE_COUNT_EN
    logic [31:0]     CycleCount;
`endif

    op_t             rom [DEPTH];
    cyc_t            exp_q [$];
    logic [PC_W-1:0] fin_pc;
    logic            fin_to;

    int n_pass;
    int n_fail;
    int n_total;

    instr_sequencer #(
        .PC_W    (PC_W),
        .MEM_LAT (MEM_LAT),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Start        (Start),
        .IsMem        (IsMem),
        .IsLoad       (IsLoad),
        .RegWrReq     (RegWrReq),
        .MemWrReq     (MemWrReq),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .IsHalt       (IsHalt),
        .PC           (PC),
        .InstrValid   (InstrValid),
        .RegWrEn      (RegWrEn),
        .MemEn        (MemEn),
        .MemWrEn      (MemWrEn),
        .Ack          (Ack),
        .TimedOut     (TimedOut)
`ifdef SEQ_CYCLE_COUNT_EN
        ,
        .CycleCount   (CycleCount)
`endif
    );

    // Asynchronous ROM + decoder.
    assign IsMem        = rom[PC].is_mem;
    assign IsLoad       = rom[PC].is_load;
    assign RegWrReq     = rom[PC].reg_wr;
    assign MemWrReq     = rom[PC].mem_wr;
    assign BranchTaken  = rom[PC].br;
    assign BranchTarget = rom[PC].tgt;
    assign IsHalt       = rom[PC].halt;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < DEPTH; i++) rom[i] = '0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "/pc"},  32'(PC), 32'd0);
        chk({tag, "/iv"},  32'(InstrValid), 32'd0);
        chk({tag, "/rw"},  32'(RegWrEn), 32'd0);
        chk({tag, "/me"},  32'(MemEn), 32'd0);
        chk({tag, "/mw"},  32'(MemWrEn), 32'd0);
        chk({tag, "/ack"}, 32'(Ack), 32'd0);
        chk({tag, "/to"},  32'(TimedOut), 32'd0);
    endtask

    // Instruction-level reference: each instruction occupies one cycle, or
    // 1+MEM_LAT cycles for a memory op; the trace ends on halt or when the
    // active-cycle count reaches TIMEOUT.
    task automatic build_model();
        logic [PC_W-1:0] pc;
        bit              done;
        op_t             r;
        cyc_t            e;
        int              n;
        exp_q.delete();
        pc     = '0;
        done   = 0;
        fin_to = 1'b0;
        while (!done) begin
            r = rom[pc];
            if (r.halt) begin
                e    = '0;
                e.pc = pc;
                e.v  = 1'b1;
                exp_q.push_back(e);
                done = 1;
            end else begin
                n = r.is_mem ? MEM_LAT + 1 : 1;
                for (int k = 0; k < n && !done; k++) begin
                    e.pc = pc;
                    e.v  = (k == 0);
                    e.me = r.is_mem;
                    e.mw = r.is_mem && (k == 0) && r.mem_wr;
                    e.rw = (k == n - 1) ? (r.is_mem ? r.is_load : r.reg_wr) : 1'b0;
                    if (exp_q.size() == TIMEOUT - 1) begin
                        e.rw   = 1'b0;
                        e.mw   = 1'b0;
                        done   = 1;
                        fin_to = 1'b1;
                    end
                    exp_q.push_back(e);
                end
                if (!done) pc = r.br ? r.tgt : PC_W'(pc + 1'b1);
            end
        end
        fin_pc = pc;
    endtask

    // Launch from IDLE/DONE, then compare every active cycle and the DONE state.
    task automatic run_prog(input string tag);
        build_model();
        @(posedge Clk);
        #1 Start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        chk({tag, "/arm_pc"},  32'(PC), 32'd0);
        chk({tag, "/arm_iv"},  32'(InstrValid), 32'd0);
        chk({tag, "/arm_ack"}, 32'(Ack), 32'd0);
        chk({tag, "/arm_to"},  32'(TimedOut), 32'd0);
        Start = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge Clk);
            chk($sformatf("%s/c%0d_pc", tag, i),  32'(PC), 32'(exp_q[i].pc));
            chk($sformatf("%s/c%0d_iv", tag, i),  32'(InstrValid), 32'(exp_q[i].v));
            chk($sformatf("%s/c%0d_rw", tag, i),  32'(RegWrEn), 32'(exp_q[i].rw));
            chk($sformatf("%s/c%0d_me", tag, i),  32'(MemEn), 32'(exp_q[i].me));
            chk($sformatf("%s/c%0d_mw", tag, i),  32'(MemWrEn), 32'(exp_q[i].mw));
            chk($sformatf("%s/c%0d_ack", tag, i), 32'(Ack), 32'd0);
            // Start activity while running must be ignored.
            Start = (i < exp_q.size() - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        @(negedge Clk);
        chk({tag, "/done_ack"}, 32'(Ack), 32'd1);
        chk({tag, "/done_to"},  32'(TimedOut), 32'(fin_to));
        chk({tag, "/done_pc"},  32'(PC), 32'(fin_pc));
        chk({tag, "/done_iv"},  32'(InstrValid), 32'd0);
        chk({tag, "/done_wr"},  32'({RegWrEn, MemEn, MemWrEn}), 32'd0);
`ifdef SEQ_CYCLE_COUNT_EN
        chk({tag, "/cc_ack"}, CycleCount, 32'(exp_q.size()));
`endif
        repeat (10) @(negedge Clk);
        chk({tag, "/hold_ack"}, 32'(Ack), 32'd1);
        chk({tag, "/hold_to"},  32'(TimedOut), 32'(fin_to));
        chk({tag, "/hold_pc"},  32'(PC), 32'(fin_pc));
`ifdef SEQ_CYCLE_COUNT_EN
        chk({tag, "/cc_hold"}, CycleCount, 32'(exp_q.size()));
`endif
    endtask

    task automatic load_test2();
        clear_rom();
        rom[0].reg_wr = 1'b1;
        rom[1].reg_wr = 1'b0;
        rom[2].reg_wr = 1'b1;
        rom[3].halt   = 1'b1;
        rom[3].reg_wr = 1'b1;
    endtask

    task automatic load_random();
        clear_rom();
        for (int i = 0; i < DEPTH; i++) begin
            if (i < 32 || i >= DEPTH - 8) begin
                rom[i].halt    = ($urandom_range(0, 9) == 0);
                rom[i].is_mem  = ($urandom_range(0, 3) == 0);
                rom[i].is_load = 1'($urandom_range(0, 1));
                rom[i].mem_wr  = 1'($urandom_range(0, 1));
                rom[i].reg_wr  = 1'($urandom_range(0, 1));
                rom[i].br      = ($urandom_range(0, 4) == 0);
                rom[i].tgt     = ($urandom_range(0, 3) == 0) ?
                                 PC_W'($urandom_range(DEPTH - 4, DEPTH - 1)) :
                                 PC_W'($urandom_range(0, 31));
            end
        end
    endtask

    initial begin
        n_pass  = 0;
        n_fail  = 0;
        n_total = 0;
        Start   = 1'b0;
        Reset_n = 1'b0;
        clear_rom();

        #1;
        chk_idle_outputs("reset");
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        chk_idle_outputs("idle");

        // Three plain ops then halt at PC=3.
        load_test2();
        run_prog("t2");

        // Load at PC=1 stretched by MEM_LAT.
        clear_rom();
        rom[1].is_mem  = 1'b1;
        rom[1].is_load = 1'b1;
        rom[2].reg_wr  = 1'b1;
        rom[3].halt    = 1'b1;
        run_prog("t3");

        // Store combined with a branch: branch lands after the wait.
        clear_rom();
        rom[0].is_mem = 1'b1;
        rom[0].mem_wr = 1'b1;
        rom[0].br     = 1'b1;
        rom[0].tgt    = PC_W'(7);
        rom[7].halt   = 1'b1;
        run_prog("st_br");

        // Branch to the top of the ROM, then wrap back to 0.
        clear_rom();
        rom[0].br          = 1'b1;
        rom[0].tgt         = PC_W'(10'h3FE);
        rom[10'h3FE].reg_wr = 1'b1;
        run_prog("t4");

        // Branch-to-self loop ends through the watchdog.
        clear_rom();
        rom[0].br     = 1'b1;
        rom[0].reg_wr = 1'b1;
        rom[0].tgt    = '0;
        run_prog("t5");

        // Relaunch out of a timed-out DONE clears Ack/TimedOut.
        load_test2();
        run_prog("t5_relaunch");

        // Randomized programs.
        for (int p = 0; p < 30; p++) begin
            load_random();
            run_prog($sformatf("rnd%0d", p));
        end

        // Asynchronous reset in the middle of a run at PC=5.
        clear_rom();
        for (int i = 0; i < 10; i++) rom[i].reg_wr = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        repeat (6) @(posedge Clk);
        @(negedge Clk);
        chk("t1/pre_pc", 32'(PC), 32'd5);
        chk("t1/pre_rw", 32'(RegWrEn), 32'd1);
        #2 Reset_n = 1'b0;
        #1;
        chk_idle_outputs("t1");
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        chk_idle_outputs("t1_after");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
